// File: rtl/pio_pkg.sv
// Shared definitions for the debounced PIO slave: bus width, register
// word addresses and a ceiling-log2 helper for sizing counters.
package pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_IN_DATA  = 3'd0;
  localparam logic [2:0] ADDR_OUT_DATA = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter and accepted value.
// 'changed' is high in the cycle whose clock edge flips q.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic q,
  output logic changed
);

  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles the synced value disagrees with the accepted one
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    changed  = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_q;
      cnt_d    = '0;
      changed  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // Synchroniser, counter and accepted-value state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= RESET_VAL;
      sync_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      meta_q   <= pin;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q = stable_q;

endmodule

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO: debounced inputs with edge capture and masked interrupt,
// plus an output register with atomic set/clear aliases.
module pio_debounce_irq
  import pio_pkg::*;
#(
  parameter int                   IN_WIDTH        = 2,
  parameter int                   OUT_WIDTH       = 10,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter logic [IN_WIDTH-1:0]  IN_RESET        = '1,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [DATA_W-1:0]    avs_writedata,
  output logic [DATA_W-1:0]    avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);

  logic [IN_WIDTH-1:0]  in_stable_s;
  logic [IN_WIDTH-1:0]  in_chg_s;
  logic [IN_WIDTH-1:0]  rise_s;
  logic [IN_WIDTH-1:0]  fall_s;
  logic [IN_WIDTH-1:0]  clr_s;
  logic [IN_WIDTH-1:0]  wr_in_s;
  logic [OUT_WIDTH-1:0] wr_out_s;
  logic [DATA_W-1:0]    rd_mux_s;
  logic                 wdata_unused_s;

  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IN_WIDTH-1:0]  mask_q, mask_d;
  logic [IN_WIDTH-1:0]  cap_q, cap_d;
  logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
  logic                 irq_q, irq_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (IN_RESET[i])
    ) u_bit (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .pin    (pio_in[i]),
      .q      (in_stable_s[i]),
      .changed(in_chg_s[i])
    );
  end

  assign wdata_unused_s = ^avs_writedata;

  // Register writes, edge capture, irq and read mux (reads see pre-write state)
  always_comb begin
    wr_in_s   = avs_writedata[IN_WIDTH-1:0];
    wr_out_s  = avs_writedata[OUT_WIDTH-1:0];
    out_d     = out_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_s     = '0;
    if (avs_write) begin
      case (avs_address)
        ADDR_OUT_DATA: out_d     = wr_out_s;
        ADDR_IRQ_MASK: mask_d    = wr_in_s;
        ADDR_EDGE_CAP: clr_s     = wr_in_s;
        ADDR_OUT_SET:  out_d     = out_q | wr_out_s;
        ADDR_OUT_CLR:  out_d     = out_q & ~wr_out_s;
        ADDR_RISE_EN:  rise_en_d = wr_in_s;
        ADDR_FALL_EN:  fall_en_d = wr_in_s;
        default:       clr_s     = '0;
      endcase
    end else begin
      clr_s = '0;
    end

    // A flip this cycle means q_next == ~q, so the edge type is set by q alone
    rise_s = in_chg_s & ~in_stable_s & rise_en_q;
    fall_s = in_chg_s &  in_stable_s & fall_en_q;
    cap_d  = (cap_q & ~clr_s) | rise_s | fall_s;
    irq_d  = |(cap_q & mask_q);

    rd_mux_s = '0;
    case (avs_address)
      ADDR_IN_DATA:  rd_mux_s[IN_WIDTH-1:0]  = in_stable_s;
      ADDR_OUT_DATA: rd_mux_s[OUT_WIDTH-1:0] = out_q;
      ADDR_IRQ_MASK: rd_mux_s[IN_WIDTH-1:0]  = mask_q;
      ADDR_EDGE_CAP: rd_mux_s[IN_WIDTH-1:0]  = cap_q;
      ADDR_RISE_EN:  rd_mux_s[IN_WIDTH-1:0]  = rise_en_q;
      ADDR_FALL_EN:  rd_mux_s[IN_WIDTH-1:0]  = fall_en_q;
      default:       rd_mux_s                = '0;
    endcase

    if (avs_read) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Register file state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q     <= OUT_RESET;
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pio_out      = out_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule
